branch_predictor: RTL and testbench

Fetch-side branch predictor that pairs with the execute-stage branch resolution logic. It holds a direct-mapped branch target buffer with one 2-bit saturating counter per entry, and predicts direction and target for the fetch PC. It is trained by the resolved outcome (taken flag and target) from execute, and it raises a mispredict/redirect to the fetch unit when the carried prediction was wrong.

---
 rtl/branch_predictor.sv | 113 +++++++++++
 tb/tb_branch_predictor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit direction counters and execute-side mispredict detection
// Optional BP_PERF_EN adds Br_Count / Mispred_Count performance counters.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IF_Valid,
  input  logic [XLEN-1:0] IF_PC,
  output logic            Pred_hit,
  output logic            Pred_taken,
  output logic [XLEN-1:0] Pred_next_pc,
  input  logic            EX_Update,
  input  logic [XLEN-1:0] EX_PC,
  input  logic            EX_Taken,
  input  logic [XLEN-1:0] EX_Target,
  input  logic            EX_Pred_taken,
  input  logic [XLEN-1:0] EX_Pred_target,
  output logic            Mispredict,
  output logic [XLEN-1:0] Redirect_PC
`ifdef BP_PERF_EN
  ,
  output logic [31:0]     Br_Count,
  output logic [31:0]     Mispred_Count
`endif
);
  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  logic            valid_q  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0] target_q [ENTRIES];
  logic [1:0]      ctr_q    [ENTRIES];

  logic [IDX-1:0]  if_idx, ex_idx;
  logic [TAGW-1:0] if_tag, ex_tag;
  logic            ex_hit;
  logic            wr_en;
  logic [1:0]      ctr_d;
  logic [XLEN-1:0] target_d;

  assign if_idx = IF_PC[IDX+1:2];
  assign if_tag = IF_PC[XLEN-1:IDX+2];
  assign ex_idx = EX_PC[IDX+1:2];
  assign ex_tag = EX_PC[XLEN-1:IDX+2];
  assign ex_hit = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  assign Pred_hit     = IF_Valid & valid_q[if_idx] & (tag_q[if_idx] == if_tag);
  assign Pred_taken   = Pred_hit & ctr_q[if_idx][1];
  assign Pred_next_pc = Pred_taken ? target_q[if_idx] : IF_PC + XLEN'(4);

  assign Mispredict  = EX_Update & ((EX_Pred_taken != EX_Taken) |
                                    (EX_Taken & EX_Pred_taken & (EX_Pred_target != EX_Target)));
  assign Redirect_PC = EX_Taken ? EX_Target : EX_PC + XLEN'(4);

  always_comb begin
    wr_en    = 1'b0;
    ctr_d    = ctr_q[ex_idx];
    target_d = target_q[ex_idx];
    if (EX_Update) begin
      if (ex_hit) begin
        wr_en = 1'b1;
        if (EX_Taken) begin
          ctr_d    = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
          target_d = EX_Target;
        end else begin
          ctr_d    = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
        end
      end else if (EX_Taken) begin
        // Allocation evicts whatever branch aliased onto this index.
        wr_en    = 1'b1;
        ctr_d    = 2'b10;
        target_d = EX_Target;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (wr_en) begin
      valid_q[ex_idx]  <= 1'b1;
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= target_d;
      ctr_q[ex_idx]    <= ctr_d;
    end
  end

`ifdef BP_PERF_EN
  logic [31:0] br_count_q, mispred_count_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      if (EX_Update)  br_count_q      <= br_count_q + 32'd1;
      if (Mispredict) mispred_count_q <= mispred_count_q + 32'd1;
    end
  end

  assign Br_Count      = br_count_q;
  assign Mispred_Count = mispred_count_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor against a per-branch table model
module tb_branch_predictor;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IF_Valid = 1'b0;
  logic [31:0] IF_PC = '0;
  logic        Pred_hit, Pred_taken, Mispredict;
  logic [31:0] Pred_next_pc, Redirect_PC;
  logic        EX_Update = 1'b0, EX_Taken = 1'b0, EX_Pred_taken = 1'b0;
  logic [31:0] EX_PC = '0, EX_Target = '0, EX_Pred_target = '0;
`ifdef BP_PERF_EN
  logic [31:0] Br_Count, Mispred_Count;
`endif

  branch_predictor #(.XLEN(32), .ENTRIES(16)) dut (
    .CLK(CLK), .RST(RST), .IF_Valid(IF_Valid), .IF_PC(IF_PC),
    .Pred_hit(Pred_hit), .Pred_taken(Pred_taken), .Pred_next_pc(Pred_next_pc),
    .EX_Update(EX_Update), .EX_PC(EX_PC), .EX_Taken(EX_Taken), .EX_Target(EX_Target),
    .EX_Pred_taken(EX_Pred_taken), .EX_Pred_target(EX_Pred_target),
    .Mispredict(Mispredict), .Redirect_PC(Redirect_PC)
`ifdef BP_PERF_EN
    , .Br_Count(Br_Count), .Mispred_Count(Mispred_Count)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        hit, taken, mis;
    logic [31:0] npc, rpc, br, mc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Model: each slot remembers the full word address of the branch it holds.
  bit          m_valid [16];
  logic [31:0] m_pc    [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int unsigned m_br = 0, m_mc = 0;

  function automatic int slot_of(logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic bit holds(logic [31:0] pc);
    int s = slot_of(pc);
    logic [31:0] p = m_pc[s];
    return m_valid[s] && (p[31:2] == pc[31:2]);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit ifv, input logic [31:0] ifpc,
                      input bit upd, input logic [31:0] expc, input bit ext,
                      input logic [31:0] extgt, input bit exptk, input logic [31:0] exptgt);
    exp_t e;
    int   s;
    @(posedge CLK);
    #1;
    RST = rst; IF_Valid = ifv; IF_PC = ifpc;
    EX_Update = upd; EX_PC = expc; EX_Taken = ext; EX_Target = extgt;
    EX_Pred_taken = exptk; EX_Pred_target = exptgt;

    s       = slot_of(ifpc);
    e.hit   = ifv && holds(ifpc);
    e.taken = e.hit && (m_ctr[s] >= 2);
    e.npc   = e.taken ? m_tgt[s] : ifpc + 32'd4;
    e.mis   = upd && ((exptk != ext) || (ext && exptgt != extgt));
    e.rpc   = ext ? extgt : expc + 32'd4;
    e.br    = m_br;
    e.mc    = m_mc;
    sb.push_back(e);

    // Advance the model to the state the next clock edge produces.
    if (rst) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      m_br = 0;
      m_mc = 0;
    end else if (upd) begin
      m_br++;
      if (e.mis) m_mc++;
      s = slot_of(expc);
      if (holds(expc)) begin
        if (ext) begin
          m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
          m_tgt[s] = extgt;
        end else begin
          m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
        end
      end else if (ext) begin
        m_valid[s] = 1;
        m_pc[s]    = expc;
        m_tgt[s]   = extgt;
        m_ctr[s]   = 2;
      end
    end
  endtask

  task automatic lookup(input logic [31:0] pc);
    step(0, 1, pc, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic train(input logic [31:0] ifpc, input logic [31:0] pc, input bit tk,
                       input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    step(0, 1, ifpc, 1, pc, tk, tgt, ptk, ptgt);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("pred_hit",     {31'b0, Pred_hit},   {31'b0, e.hit});
      chk("pred_taken",   {31'b0, Pred_taken}, {31'b0, e.taken});
      chk("pred_next_pc", Pred_next_pc,        e.npc);
      chk("mispredict",   {31'b0, Mispredict}, {31'b0, e.mis});
      chk("redirect_pc",  Redirect_PC,         e.rpc);
`ifdef BP_PERF_EN
      chk("br_count",      Br_Count,      e.br);
      chk("mispred_count", Mispred_Count, e.mc);
`endif
    end
  end

  function automatic logic [31:0] rnd_pc();
    if ($urandom_range(0, 15) == 0)
      return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    return 32'h100 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] tg;
    foreach (m_valid[i]) begin
      m_valid[i] = 0; m_pc[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    step(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    step(1, 1, 32'h100, 1, 32'h100, 1, 32'h40, 0, 32'h0);

    lookup(32'h100);
    train(32'h100, 32'h100, 1, 32'h40, 0, 32'h0);
    lookup(32'h100);
    repeat (3) train(32'h100, 32'h100, 1, 32'h40, 1, 32'h40);
    repeat (2) train(32'h100, 32'h100, 0, 32'h0, 1, 32'h40);
    lookup(32'h100);
    repeat (2) train(32'h100, 32'h100, 0, 32'h0, 0, 32'h0);
    lookup(32'h100);
    train(32'h140, 32'h140, 1, 32'h40, 0, 32'h0);
    lookup(32'h100);
    lookup(32'h140);
    train(32'h140, 32'h140, 1, 32'h80, 1, 32'h40);
    lookup(32'h140);
    train(32'h100, 32'h100, 1, 32'h60, 0, 32'h0);
    train(32'h100, 32'h100, 0, 32'h0, 1, 32'h60);
    lookup(32'h100);
    lookup(32'hFFFF_FFFC);
    step(0, 0, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    train(32'h200, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h8);
    step(1, 1, 32'h140, 1, 32'h140, 1, 32'h44, 0, 32'h0);
    lookup(32'h140);

    for (int n = 0; n < 3000; n++) begin
      tg = 32'h1000 | (32'($urandom_range(0, 7)) << 2);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, rnd_pc(),
           $urandom_range(0, 1) == 1, rnd_pc(), $urandom_range(0, 1) == 1, tg,
           $urandom_range(0, 1) == 1,
           ($urandom_range(0, 1) == 1) ? tg : 32'h1000 | (32'($urandom_range(0, 7)) << 2));
    end

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge CLK);
    @(negedge CLK);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
